lsu: RTL and testbench
======================

# lsu

Load-store unit for the single-cycle RV32I core; sits directly downstream of `alu`, whose `alu_data_o` drives the effective address `addr_i`. It decodes the address into 2 KiB data memory, memory-mapped output registers and a switch input port. It performs byte, half and word stores on the clock edge, and returns combinational sign/zero-extended load data to writeback.

## Interface
Parameters:
- `DMEM_WORDS`, 512, data memory depth in 32-bit words; 2 KiB, occupies address bits [10:2].

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge
- `rst_ni`  in  1  reset; asynchronous, active-low
- `addr_i`  in  32  effective byte address (`alu_data_o`)
- `st_data_i`  in  32  store data (rs2)
- `st_en_i`  in  1  store request this cycle
- `lsu_op_i`  in  3  access type, RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU; others are illegal
- `ld_data_o`  out  32  extended load data, combinational
- `misalign_o`  out  1  access not naturally aligned, combinational
- `io_sw_i`  in  32  board switches, asynchronous to `clk_i`
- `io_ledr_o`  out  32  red LED register
- `io_ledg_o`  out  32  green LED register
- `io_hex_o`  out  32  7-seg register, 4 bits per digit
- `io_lcd_o`  out  32  LCD control/data register

## Operation
Address map, full 32-bit compare on the upper bits:
- 0x0000_0000–0x0000_07FF: DMEM, read/write
- 0x0000_7000–7003: LEDR
- 0x0000_7010–7013: LEDG
- 0x0000_7020–7023: HEX
- 0x0000_7030–7033: LCD
- 0x0000_7800–7803: SW, read-only
- Any other address is unmapped.

Access rules:
- Byte lane = `addr_i[1:0]`. H requires `addr_i[0]`=0; W requires `addr_i[1:0]`=0. Violation sets `misalign_o`=1.
- Store: on edge with `st_en_i`=1, aligned, mapped and writable, write only the addressed lanes. B writes `st_data_i[7:0]` into lane n; H writes `st_data_i[15:0]` into lanes n and n+1.
- Stores are suppressed when misaligned, unmapped, to SW, or when `lsu_op_i` is illegal.
- Load: select the addressed lanes from the target word and place them at [7:0] or [15:0]. B and H sign-extend; BU and HU zero-extend; W passes through.
- Output registers read back their current value.
- `ld_data_o`=0 when the access is misaligned, unmapped, or `lsu_op_i` is illegal.
- `ld_data_o` is driven regardless of `st_en_i`. Writeback ignores it on stores.

## Timing
- Reset (`rst_ni`=0, asynchronous): `io_ledr_o`, `io_ledg_o`, `io_hex_o` and `io_lcd_o` = 0; switch synchronizer flops = 0. DMEM is not reset; its contents are undefined.
- `ld_data_o` and `misalign_o` are purely combinational from `addr_i`, `lsu_op_i` and current state.
- Load latency is 0 cycles.
- Store latency is 1 edge. An `io_*_o` register reflects the new value immediately after the edge.
- Store and load to the same address in the same cycle: `ld_data_o` shows the old data until the edge.
- Consecutive stores on back-to-back cycles all take effect; there is no back-pressure.
- Reset asserted mid-cycle clears the I/O registers at once. A store in that cycle is lost for I/O; the DMEM write is unspecified.
- Reset deassertion is synchronized externally; the block assumes deassertion meets recovery/removal timing.

## Configuration
- `LSU_SW_SYNC_EN` defined: `io_sw_i` passes through a 2-flop synchronizer, reset to 0. A SW load returns the value sampled 2 edges earlier.
- `LSU_SW_SYNC_EN` undefined: a SW load returns `io_sw_i` combinationally with no flops. Use this for simulation-only cores.

## Test plan
- SW 0x8765_4321 to 0x100, then LW 0x100 → `ld_data_o`=0x8765_4321. LB 0x101 → 0x0000_0043. LB 0x103 → 0xFFFF_FF87. LBU 0x103 → 0x0000_0087.
- SB 0xAA to 0x7002 with LEDR=0 → after the edge `io_ledr_o`=0x00AA_0000, other output registers unchanged. LHU 0x7002 → 0x0000_00AA.
- SH to 0x0000_0201 → `misalign_o`=1, memory unchanged, `ld_data_o`=0. LW 0x0000_0202 → `misalign_o`=1.
- SW to 0x0000_5000 (unmapped) and to 0x7800 (SW) → no state change. LW 0x5000 → 0.
- `io_sw_i`=0x0000_1234 with `LSU_SW_SYNC_EN` defined → LW 0x7800 returns 0 on the first edge and 0x1234 from the second edge onward. With the macro undefined → 0x1234 immediately.
- Write 0xFFFF_FFFF to all four output registers, pull `rst_ni` low between edges → all four `io_*_o` = 0 with no clock edge. DMEM word at 0x100 is not checked.

Source files
------------

// File: rtl/lsu.sv
// Load-store unit: 2 KiB DMEM, four memory-mapped output registers and a switch port.
// Define LSU_SW_SYNC_EN to pass io_sw_i through a 2-flop synchronizer before it is read.
module lsu #(
  parameter int DMEM_WORDS = 512
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] addr_i,
  input  logic [31:0] st_data_i,
  input  logic        st_en_i,
  input  logic [2:0]  lsu_op_i,
  output logic [31:0] ld_data_o,
  output logic        misalign_o,
  input  logic [31:0] io_sw_i,
  output logic [31:0] io_ledr_o,
  output logic [31:0] io_ledg_o,
  output logic [31:0] io_hex_o,
  output logic [31:0] io_lcd_o
);

  localparam int AW = $clog2(DMEM_WORDS);

  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;

  logic [31:0] dmem [DMEM_WORDS];
  logic [31:0] ledr_q, ledr_d, ledg_q, ledg_d, hex_q, hex_d, lcd_q, lcd_d;
  logic [31:0] swVal;
  logic        legalOp, misalign, storeOk, mapped;
  logic        isDmem, isLedr, isLedg, isHex, isLcd, isSw;
  logic [3:0]  byteEn;
  logic [31:0] wrData, rdWord, shifted;
  logic [AW-1:0] wordIdx;

  assign wordIdx = addr_i[AW+1:2];

  always_comb begin
    isDmem = (addr_i[31:AW+2] == '0);
    isLedr = (addr_i[31:2] == 30'h0000_1C00);
    isLedg = (addr_i[31:2] == 30'h0000_1C04);
    isHex  = (addr_i[31:2] == 30'h0000_1C08);
    isLcd  = (addr_i[31:2] == 30'h0000_1C0C);
    isSw   = (addr_i[31:2] == 30'h0000_1E00);
    mapped = isDmem | isLedr | isLedg | isHex | isLcd | isSw;
  end

  // Sub-word stores replicate the data across lanes so the byte enables pick the right copy.
  always_comb begin
    legalOp  = 1'b0;
    misalign = 1'b0;
    byteEn   = 4'b0000;
    wrData   = st_data_i;
    case (lsu_op_i)
      OP_B, OP_BU: begin
        legalOp = 1'b1;
        byteEn  = 4'b0001 << addr_i[1:0];
        wrData  = {4{st_data_i[7:0]}};
      end
      OP_H, OP_HU: begin
        legalOp  = 1'b1;
        misalign = addr_i[0];
        byteEn   = 4'b0011 << addr_i[1:0];
        wrData   = {2{st_data_i[15:0]}};
      end
      OP_W: begin
        legalOp  = 1'b1;
        misalign = |addr_i[1:0];
        byteEn   = 4'b1111;
      end
      default: ;
    endcase
  end

  assign storeOk    = st_en_i & legalOp & ~misalign & (isDmem | isLedr | isLedg | isHex | isLcd);
  assign misalign_o = misalign;

  function automatic logic [31:0] mergeLanes(input logic [31:0] oldW, input logic [31:0] newW,
                                             input logic [3:0] be);
    logic [31:0] res;
    res = oldW;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = newW[8*i +: 8];
    end
    return res;
  endfunction

  always_comb begin
    ledr_d = (storeOk && isLedr) ? mergeLanes(ledr_q, wrData, byteEn) : ledr_q;
    ledg_d = (storeOk && isLedg) ? mergeLanes(ledg_q, wrData, byteEn) : ledg_q;
    hex_d  = (storeOk && isHex)  ? mergeLanes(hex_q,  wrData, byteEn) : hex_q;
    lcd_d  = (storeOk && isLcd)  ? mergeLanes(lcd_q,  wrData, byteEn) : lcd_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ledr_q <= '0;
      ledg_q <= '0;
      hex_q  <= '0;
      lcd_q  <= '0;
    end else begin
      ledr_q <= ledr_d;
      ledg_q <= ledg_d;
      hex_q  <= hex_d;
      lcd_q  <= lcd_d;
    end
  end

  assign io_ledr_o = ledr_q;
  assign io_ledg_o = ledg_q;
  assign io_hex_o  = hex_q;
  assign io_lcd_o  = lcd_q;

  // DMEM has no reset so it can map onto block RAM with byte-write enables.
  always_ff @(posedge clk_i) begin
    if (storeOk && isDmem) begin
      for (int i = 0; i < 4; i++) begin
        if (byteEn[i]) dmem[wordIdx][8*i +: 8] <= wrData[8*i +: 8];
      end
    end
  end

`ifdef LSU_SW_SYNC_EN
  logic [31:0] swMeta_q, swSync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      swMeta_q <= '0;
      swSync_q <= '0;
    end else begin
      swMeta_q <= io_sw_i;
      swSync_q <= swMeta_q;
    end
  end

  assign swVal = swSync_q;
`else
  assign swVal = io_sw_i;
`endif

  always_comb begin
    rdWord = '0;
    if (isDmem)      rdWord = dmem[wordIdx];
    else if (isLedr) rdWord = ledr_q;
    else if (isLedg) rdWord = ledg_q;
    else if (isHex)  rdWord = hex_q;
    else if (isLcd)  rdWord = lcd_q;
    else if (isSw)   rdWord = swVal;
  end

  assign shifted = rdWord >> {addr_i[1:0], 3'b000};

  always_comb begin
    ld_data_o = '0;
    if (legalOp && !misalign && mapped) begin
      case (lsu_op_i)
        OP_B:    ld_data_o = {{24{shifted[7]}}, shifted[7:0]};
        OP_BU:   ld_data_o = {24'h0, shifted[7:0]};
        OP_H:    ld_data_o = {{16{shifted[15]}}, shifted[15:0]};
        OP_HU:   ld_data_o = {16'h0, shifted[15:0]};
        default: ld_data_o = shifted;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed vector table, switch/reset sequences, and
// randomized traffic compared against a byte-addressed reference model.
module tb_lsu;

  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;

  logic        clk, rstN;
  logic [31:0] addr, stData, ldData, ioSw;
  logic [31:0] ioLedr, ioLedg, ioHex, ioLcd;
  logic        stEn, misalign;
  logic [2:0]  lsuOp;

  int checks   = 0;
  int failures = 0;

  lsu #(.DMEM_WORDS(512)) dut (
    .clk_i(clk), .rst_ni(rstN), .addr_i(addr), .st_data_i(stData), .st_en_i(stEn),
    .lsu_op_i(lsuOp), .ld_data_o(ldData), .misalign_o(misalign), .io_sw_i(ioSw),
    .io_ledr_o(ioLedr), .io_ledg_o(ioLedg), .io_hex_o(ioHex), .io_lcd_o(ioLcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model: memory as a flat byte array, I/O as four words, switches as a sample history.
  logic [7:0]  dmemModel [2048];
  logic [31:0] ioModel [4];
  logic [31:0] swHist [$];

  always @(posedge clk or negedge rstN) begin
    if (!rstN) swHist.delete();
    else begin
      swHist.push_front(ioSw);
      if (swHist.size() > 2) void'(swHist.pop_back());
    end
  end

  function automatic logic [31:0] swNow();
`ifdef LSU_SW_SYNC_EN
    return (swHist.size() >= 2) ? swHist[1] : 32'h0;
`else
    return ioSw;
`endif
  endfunction

  function automatic int opSize(logic [2:0] op);
    case (op)
      OP_B, OP_BU: return 1;
      OP_H, OP_HU: return 2;
      OP_W:        return 4;
      default:     return 0;
    endcase
  endfunction

  function automatic int ioIndex(logic [31:0] a);
    for (int i = 0; i < 4; i++)
      if (a >= 32'h7000 + 32'(16 * i) && a < 32'h7004 + 32'(16 * i)) return i;
    return -1;
  endfunction

  function automatic logic [7:0] readByte(logic [31:0] a);
    int idx = ioIndex(a);
    int sh  = 8 * int'(a[1:0]);
    logic [31:0] w;
    if (a < 32'd2048) return dmemModel[a[10:0]];
    if (idx >= 0) begin
      w = ioModel[idx] >> sh;
      return w[7:0];
    end
    if (a >= 32'h7800 && a < 32'h7804) begin
      w = swNow() >> sh;
      return w[7:0];
    end
    return 8'h00;
  endfunction

  function automatic bit isMapped(logic [31:0] a);
    return (a < 32'd2048) || (ioIndex(a) >= 0) || (a >= 32'h7800 && a < 32'h7804);
  endfunction

  function automatic logic [31:0] modelLoad(logic [31:0] a, logic [2:0] op);
    int sz = opSize(op);
    logic [31:0] v = 32'h0;
    if (sz == 0 || (a % sz) != 0 || !isMapped(a)) return 32'h0;
    for (int k = 0; k < sz; k++) v = v | (32'(readByte(a + 32'(k))) << (8 * k));
    if (op == OP_B && v[7])  v = v | 32'hFFFF_FF00;
    if (op == OP_H && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  function automatic logic modelMis(logic [31:0] a, logic [2:0] op);
    int sz = opSize(op);
    return (sz > 1) && ((a % sz) != 0);
  endfunction

  task automatic modelStore(input logic [31:0] a, input logic [31:0] d, input logic [2:0] op);
    int sz = opSize(op);
    logic [31:0] ba;
    logic [7:0]  b;
    int idx, sh;
    if (sz == 0 || (a % sz) != 0) return;
    if (!(a < 32'd2048 || ioIndex(a) >= 0)) return;
    for (int k = 0; k < sz; k++) begin
      ba = a + 32'(k);
      b  = 8'(d >> (8 * k));
      if (ba < 32'd2048) dmemModel[ba[10:0]] = b;
      else begin
        idx = ioIndex(ba);
        sh  = 8 * int'(ba[1:0]);
        ioModel[idx] = (ioModel[idx] & ~(32'hFF << sh)) | (32'(b) << sh);
      end
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Drives one access mid-cycle and leaves the combinational outputs settled.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d, input logic en,
                               input logic [2:0] op);
    @(negedge clk);
    addr = a; stData = d; stEn = en; lsuOp = op;
    #1;
  endtask

  task automatic commitEdge();
    @(posedge clk);
    if (stEn) modelStore(addr, stData, lsuOp);
    #1;
    stEn = 1'b0;
  endtask

  task automatic checkIoRegs(input string tag);
    checkOutput({tag, " ledr"}, ioLedr, ioModel[0]);
    checkOutput({tag, " ledg"}, ioLedg, ioModel[1]);
    checkOutput({tag, " hex"},  ioHex,  ioModel[2]);
    checkOutput({tag, " lcd"},  ioLcd,  ioModel[3]);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic        en;
    logic [2:0]  op;
    logic        chkLd;
    logic [31:0] expLd;
    logic        expMis;
  } vec_t;

  vec_t vecs [28];

  initial begin
    vecs[0]  = '{32'h0000_0100, 32'h8765_4321, 1'b1, OP_W,   1'b0, 32'h0,         1'b0};
    vecs[1]  = '{32'h0000_0200, 32'h0000_0000, 1'b1, OP_W,   1'b0, 32'h0,         1'b0};
    vecs[2]  = '{32'h0000_0100, 32'h0,         1'b0, OP_W,   1'b1, 32'h8765_4321, 1'b0};
    vecs[3]  = '{32'h0000_0101, 32'h0,         1'b0, OP_B,   1'b1, 32'h0000_0043, 1'b0};
    vecs[4]  = '{32'h0000_0103, 32'h0,         1'b0, OP_B,   1'b1, 32'hFFFF_FF87, 1'b0};
    vecs[5]  = '{32'h0000_0103, 32'h0,         1'b0, OP_BU,  1'b1, 32'h0000_0087, 1'b0};
    vecs[6]  = '{32'h0000_0102, 32'h0,         1'b0, OP_H,   1'b1, 32'hFFFF_8765, 1'b0};
    vecs[7]  = '{32'h0000_0100, 32'h0,         1'b0, OP_HU,  1'b1, 32'h0000_4321, 1'b0};
    vecs[8]  = '{32'h0000_7002, 32'h1234_56AA, 1'b1, OP_B,   1'b1, 32'h0,         1'b0};
    vecs[9]  = '{32'h0000_7002, 32'h0,         1'b0, OP_HU,  1'b1, 32'h0000_00AA, 1'b0};
    vecs[10] = '{32'h0000_7000, 32'h0,         1'b0, OP_W,   1'b1, 32'h00AA_0000, 1'b0};
    vecs[11] = '{32'h0000_0201, 32'h0000_BEEF, 1'b1, OP_H,   1'b1, 32'h0,         1'b1};
    vecs[12] = '{32'h0000_0200, 32'h0,         1'b0, OP_W,   1'b1, 32'h0,         1'b0};
    vecs[13] = '{32'h0000_0202, 32'h0,         1'b0, OP_W,   1'b1, 32'h0,         1'b1};
    vecs[14] = '{32'h0000_5000, 32'hDEAD_BEEF, 1'b1, OP_W,   1'b1, 32'h0,         1'b0};
    vecs[15] = '{32'h0000_5000, 32'h0,         1'b0, OP_W,   1'b1, 32'h0,         1'b0};
    vecs[16] = '{32'h0000_7800, 32'h1111_1111, 1'b1, OP_W,   1'b1, 32'h0,         1'b0};
    vecs[17] = '{32'h0000_7800, 32'h0,         1'b0, OP_W,   1'b1, 32'h0,         1'b0};
    vecs[18] = '{32'h0000_0100, 32'hFFFF_FFFF, 1'b1, 3'b011, 1'b1, 32'h0,         1'b0};
    vecs[19] = '{32'h0000_0100, 32'h0,         1'b0, OP_W,   1'b1, 32'h8765_4321, 1'b0};
    vecs[20] = '{32'h0000_0100, 32'hCAFE_F00D, 1'b1, OP_W,   1'b1, 32'h8765_4321, 1'b0};
    vecs[21] = '{32'h0000_0100, 32'h0,         1'b0, OP_W,   1'b1, 32'hCAFE_F00D, 1'b0};
    vecs[22] = '{32'h0000_7012, 32'h1234_BEEF, 1'b1, OP_H,   1'b1, 32'h0,         1'b0};
    vecs[23] = '{32'h0000_7010, 32'h0,         1'b0, OP_W,   1'b1, 32'hBEEF_0000, 1'b0};
    vecs[24] = '{32'h0000_7031, 32'h0000_005A, 1'b1, OP_B,   1'b1, 32'h0,         1'b0};
    vecs[25] = '{32'h0000_7031, 32'h0,         1'b0, OP_BU,  1'b1, 32'h0000_005A, 1'b0};
    vecs[26] = '{32'h0000_7020, 32'h0,         1'b0, OP_W,   1'b1, 32'h0,         1'b0};
    vecs[27] = '{32'h0001_0100, 32'h0,         1'b0, OP_W,   1'b1, 32'h0,         1'b0};
  end

  initial begin
    logic [31:0] ra, rd, pick;
    logic [2:0]  rop;
    logic [2:0]  legalOps [5];
    legalOps = '{OP_B, OP_H, OP_W, OP_BU, OP_HU};
    for (int i = 0; i < 2048; i++) dmemModel[i] = 8'h00;
    for (int i = 0; i < 4; i++) ioModel[i] = 32'h0;

    rstN = 1'b0; ioSw = 32'h0; addr = 32'h0; stData = 32'h0; stEn = 1'b0; lsuOp = OP_W;
    #12;
    checkIoRegs("reset");
    @(negedge clk);
    rstN = 1'b1;

    $display("[TB] directed vector table");
    for (int i = 0; i < 28; i++) begin
      applyStimulus(vecs[i].a, vecs[i].d, vecs[i].en, vecs[i].op);
      if (vecs[i].chkLd) checkOutput($sformatf("vec%0d ld", i), ldData, vecs[i].expLd);
      checkOutput($sformatf("vec%0d mis", i), 32'(misalign), 32'(vecs[i].expMis));
      commitEdge();
    end
    checkOutput("table ledr", ioLedr, 32'h00AA_0000);
    checkOutput("table ledg", ioLedg, 32'hBEEF_0000);
    checkOutput("table hex",  ioHex,  32'h0);
    checkOutput("table lcd",  ioLcd,  32'h0000_5A00);

    $display("[TB] switch port sequence");
    applyStimulus(32'h7800, 32'h0, 1'b0, OP_W);
    ioSw = 32'h0000_1234;
    #1;
`ifdef LSU_SW_SYNC_EN
    checkOutput("sw before edge", ldData, 32'h0);
    commitEdge();
    applyStimulus(32'h7800, 32'h0, 1'b0, OP_W);
    checkOutput("sw after 1 edge", ldData, 32'h0);
    commitEdge();
    applyStimulus(32'h7800, 32'h0, 1'b0, OP_W);
    checkOutput("sw after 2 edges", ldData, 32'h0000_1234);
    commitEdge();
    applyStimulus(32'h7800, 32'h0, 1'b0, OP_W);
    checkOutput("sw after 3 edges", ldData, 32'h0000_1234);
`else
    checkOutput("sw immediate", ldData, 32'h0000_1234);
    applyStimulus(32'h7802, 32'h0, 1'b0, OP_HU);
    checkOutput("sw upper half", ldData, 32'h0);
`endif
    commitEdge();

    $display("[TB] randomized traffic");
    for (int w = 0; w < 16; w++) begin
      applyStimulus(32'h100 + 32'(4 * w), $urandom, 1'b1, OP_W);
      commitEdge();
    end
    for (int n = 0; n < 400; n++) begin
      pick = 32'($urandom_range(0, 9));
      if (pick <= 4 || pick == 9) ra = 32'h100 + 32'($urandom_range(0, 63));
      else if (pick <= 6) ra = 32'h7000 + 32'(16 * $urandom_range(0, 3)) + 32'($urandom_range(0, 3));
      else if (pick == 7) ra = 32'h7800 + 32'($urandom_range(0, 3));
      else begin
        case ($urandom_range(0, 4))
          0: ra = 32'h800 + 32'($urandom_range(0, 15));
          1: ra = 32'h7004 + 32'($urandom_range(0, 11));
          2: ra = 32'h0001_0100 + 32'($urandom_range(0, 15));
          3: ra = 32'h7040 + 32'($urandom_range(0, 3));
          default: ra = 32'h8000_7000 + 32'($urandom_range(0, 3));
        endcase
      end
      if ($urandom_range(0, 15) < 14) rop = legalOps[$urandom_range(0, 4)];
      else begin
        case ($urandom_range(0, 2))
          0: rop = 3'b011;
          1: rop = 3'b110;
          default: rop = 3'b111;
        endcase
      end
      rd = $urandom;
      applyStimulus(ra, rd, 1'($urandom_range(0, 1)), rop);
      ioSw = $urandom;
      #1;
      checkOutput($sformatf("rand%0d ld @%08h op%0d", n, ra, rop), ldData, modelLoad(ra, rop));
      if (opSize(rop) != 0)
        checkOutput($sformatf("rand%0d mis", n), 32'(misalign), 32'(modelMis(ra, rop)));
      commitEdge();
      checkIoRegs($sformatf("rand%0d", n));
    end

    $display("[TB] asynchronous reset sequence");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(32'h7000 + 32'(16 * i), 32'hFFFF_FFFF, 1'b1, OP_W);
      commitEdge();
    end
    checkIoRegs("preset");
    @(negedge clk);
    #2;
    rstN = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) ioModel[i] = 32'h0;
    checkOutput("async reset ledr", ioLedr, 32'h0);
    checkOutput("async reset ledg", ioLedg, 32'h0);
    checkOutput("async reset hex",  ioHex,  32'h0);
    checkOutput("async reset lcd",  ioLcd,  32'h0);
    @(negedge clk);
    rstN = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
